// File: rtl/median_window_gen_if.sv
// median_window_gen_if
//   Stream bundle around the 3x3 window generator.
//   Input side : s_valid / s_ready / s_data carry one raster-order pixel per
//                handshake.
//   Output side: m_valid / m_ready / m_win / m_row / m_col carry one 3x3
//                window with its centre coordinates.
//   frame_done : one-cycle pulse after the last window of a frame.
//   slave  modport : the window generator.
//   master modport : the pixel source and window sink.
interface median_window_gen_if #(
  parameter int DATA_W = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_W-1:0]     s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [9*DATA_W-1:0]   m_win;
  logic [15:0]           m_row;
  logic [15:0]           m_col;
  logic                  frame_done;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_win, m_row, m_col, frame_done
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_win, m_row, m_col, frame_done
  );
endinterface

// File: rtl/median_window_gen.sv
// median_window_gen
//   Streaming 3x3 neighbourhood generator in front of the median core.
//   Buffers the two previous image lines and emits one window per interior
//   pixel (no border windows), tagged with the window centre row/column.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : median_window_gen_if.slave (pixel in, window out, frame_done)
//   m_win slice k (bits k*DATA_W +: DATA_W) is window element k, row-major,
//   k=0 top-left, k=4 centre, k=8 bottom-right.
module median_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  median_window_gen_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]             col;
  logic [RW-1:0]             row;
  logic [DATA_W-1:0]         lb0 [IMG_W];
  logic [DATA_W-1:0]         lb1 [IMG_W];
  logic [8:0][DATA_W-1:0]    win_q;
  logic [8:0][DATA_W-1:0]    win_nxt;

  logic                      rdy_en;
  logic                      mv_q;
  logic [9*DATA_W-1:0]       mwin_q;
  logic [15:0]               mrow_q;
  logic [15:0]               mcol_q;
  logic                      fd_q;

  logic                      acc;
  logic                      out_xfer;
  logic                      col_last;
  logic                      row_last;
  logic                      emit;

  assign acc      = bus.s_valid && bus.s_ready;
  assign out_xfer = mv_q && bus.m_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign emit     = acc && (row >= RW'(2)) && (col >= CW'(2));

  // Shift the window one column left; the new right column is
  // {row r-2, row r-1, row r} taken from lb1, lb0 and the incoming pixel.
  assign win_nxt = {bus.s_data, win_q[8:7], lb0[col], win_q[5:4], lb1[col], win_q[2:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FILL:  if (acc && col_last && (row == RW'(1))) state_nxt = S_RUN;
      S_RUN:   if (acc && col_last && row_last)        state_nxt = S_FLUSH;
      S_FLUSH: if (out_xfer)                           state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // Output logic: rdy_en keeps s_ready low throughout reset.
  always_comb begin
    bus.s_ready = rdy_en && (state != S_FLUSH) && (!mv_q || bus.m_ready);
  end

  // Line buffers carry no reset; their contents are rewritten every frame.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
      col    <= '0;
      row    <= '0;
      win_q  <= '0;
      mv_q   <= 1'b0;
      mwin_q <= '0;
      mrow_q <= '0;
      mcol_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      fd_q   <= (state == S_FLUSH) && out_xfer;

      if (acc) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // Window shifter restarts from zero at each new frame.
      if ((state == S_FLUSH) && out_xfer) win_q <= '0;
      else if (acc)                       win_q <= win_nxt;

      if (emit) begin
        mv_q   <= 1'b1;
        mwin_q <= win_nxt;
        mrow_q <= 16'(row) - 16'd1;
        mcol_q <= 16'(col) - 16'd1;
      end else if (out_xfer) begin
        mv_q   <= 1'b0;
      end
    end
  end

  assign bus.m_valid    = mv_q;
  assign bus.m_win      = mwin_q;
  assign bus.m_row      = mrow_q;
  assign bus.m_col      = mcol_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_median_window_gen.sv
// tb_median_window_gen
//   Self-checking bench for median_window_gen. Three instances share a clock:
//   dut0 4x4 (ramp, backpressure, back-to-back, reset), dut1 8x8 (input gaps),
//   dut2 5x5 (impulse). Expected windows are built from a bench-side image copy
//   and queued when the pixel is driven, then popped on each output handshake.
module tb_median_window_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] win;
    logic [15:0] row;
    logic [15:0] col;
  } exp_t;

  logic        sv   [3];
  logic [7:0]  sd   [3];
  logic        mr   [3];
  logic        srdy [3];
  logic        mv   [3];
  logic [71:0] mw   [3];
  logic [15:0] mrow [3];
  logic [15:0] mcol [3];
  logic        fdn  [3];

  median_window_gen_if #(.DATA_W(8)) if0 ();
  median_window_gen_if #(.DATA_W(8)) if1 ();
  median_window_gen_if #(.DATA_W(8)) if2 ();

  median_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  median_window_gen #(.DATA_W(8), .IMG_W(8), .IMG_H(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  median_window_gen #(.DATA_W(8), .IMG_W(5), .IMG_H(5)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.s_valid = sv[0]; assign if0.s_data = sd[0]; assign if0.m_ready = mr[0];
  assign if1.s_valid = sv[1]; assign if1.s_data = sd[1]; assign if1.m_ready = mr[1];
  assign if2.s_valid = sv[2]; assign if2.s_data = sd[2]; assign if2.m_ready = mr[2];

  assign srdy[0] = if0.s_ready; assign mv[0] = if0.m_valid; assign mw[0] = if0.m_win;
  assign mrow[0] = if0.m_row;   assign mcol[0] = if0.m_col; assign fdn[0] = if0.frame_done;
  assign srdy[1] = if1.s_ready; assign mv[1] = if1.m_valid; assign mw[1] = if1.m_win;
  assign mrow[1] = if1.m_row;   assign mcol[1] = if1.m_col; assign fdn[1] = if1.frame_done;
  assign srdy[2] = if2.s_ready; assign mv[2] = if2.m_valid; assign mw[2] = if2.m_win;
  assign mrow[2] = if2.m_row;   assign mcol[2] = if2.m_col; assign fdn[2] = if2.frame_done;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int   checks = 0;
  int   errors = 0;
  int   win_cnt [3];
  int   fd_cnt  [3];
  exp_t first_w [3];
  exp_t last_w  [3];
  bit   drv_done;

  function automatic int dim(input int d);
    case (d)
      0:       return 4;
      1:       return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t qpop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic [7:0] med9(input logic [71:0] w);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int k = 0; k < 9; k++) a[k] = w[k*8 +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[4];
  endfunction

  // Drive one frame (or its first npix pixels) into dut d, queueing the
  // expected window for every interior pixel as it is driven.
  task automatic run_frame(input int d, input int mode, input int base, input bit gaps, input int npix);
    int         w, cnt;
    logic [7:0] img [8][8];
    logic [7:0] pix;
    exp_t       e;
    w = dim(d);
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r * w + c >= npix) begin
          sv[d] = 1'b0;
          drv_done = 1'b1;
          return;
        end
        pix = (mode == 0) ? 8'(base + w * r + c) : ((r == 2 && c == 2) ? 8'd255 : 8'd10);
        img[r][c] = pix;
        if (r >= 2 && c >= 2) begin
          for (int k = 0; k < 9; k++) e.win[k*8 +: 8] = img[r - 2 + k / 3][c - 2 + k % 3];
          e.row = 16'(r - 1);
          e.col = 16'(c - 1);
          qpush(d, e);
        end
        if (gaps) begin
          while ($urandom_range(0, 2) == 0) begin
            sv[d] = 1'b0;
            sd[d] = 8'($urandom);
            @(posedge clk); #1;
          end
        end
        sv[d] = 1'b1;
        sd[d] = pix;
        cnt = 0;
        @(negedge clk);
        while (!srdy[d]) begin
          cnt++;
          if (cnt > 2000) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut%0d: pixel (%0d,%0d) not accepted, s_ready=%b required 1", d, r, c, srdy[d]);
            sv[d] = 1'b0;
            drv_done = 1'b1;
            return;
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
      end
    end
    sv[d] = 1'b0;
    drv_done = 1'b1;
  endtask

  // Scoreboard side: pop and compare on every output handshake of dut d.
  task automatic watch(input int d, input bit need_fd);
    int   cyc, n255;
    bit   fd_seen;
    exp_t e, got;
    cyc = 0;
    fd_seen = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (mv[d] && mr[d]) begin
        got = {mw[d], mrow[d], mcol[d]};
        checks++;
        if (qsize(d) == 0) begin
          errors++;
          $display("FAIL unexpected_window dut%0d: got row=%0d col=%0d, required no window", d, got.row, got.col);
        end else begin
          e = qpop(d);
          if (got !== e) begin
            errors++;
            $display("FAIL window dut%0d: got win=%h row=%0d col=%0d, required win=%h row=%0d col=%0d",
                     d, got.win, got.row, got.col, e.win, e.row, e.col);
          end
        end
        if (win_cnt[d] == 0) first_w[d] = got;
        last_w[d] = got;
        win_cnt[d]++;
        if (d == 2) begin
          n255 = 0;
          for (int k = 0; k < 9; k++) if (mw[2][k*8 +: 8] == 8'd255) n255++;
          checks++;
          if (n255 != 1) begin
            errors++;
            $display("FAIL impulse_count at (%0d,%0d): got %0d samples of 255, required 1", mrow[2], mcol[2], n255);
          end
          checks++;
          if (med9(mw[2]) !== 8'd10) begin
            errors++;
            $display("FAIL impulse_median at (%0d,%0d): got %0d, required 10", mrow[2], mcol[2], med9(mw[2]));
          end
        end
      end
      if (fdn[d]) begin
        fd_cnt[d]++;
        fd_seen = 1'b1;
        checks++;
        if (srdy[d] !== 1'b1) begin
          errors++;
          $display("FAIL ready_at_frame_done dut%0d: got s_ready=%b, required 1", d, srdy[d]);
        end
      end
      if (need_fd ? fd_seen : (drv_done && qsize(d) == 0 && !mv[d])) break;
      if (cyc > 20000) begin
        checks++; errors++;
        $display("FAIL watch_timeout dut%0d: got %0d windows pending, required frame completion", d, qsize(d));
        break;
      end
    end
    if (need_fd) begin
      checks++;
      if (qsize(d) != 0) begin
        errors++;
        $display("FAIL lost_windows dut%0d: got %0d undelivered, required 0", d, qsize(d));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (srdy[d] !== 1'b0 || mv[d] !== 1'b0 || fdn[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d: got s_ready=%b m_valid=%b frame_done=%b, required 0 0 0", d, srdy[d], mv[d], fdn[d]);
      end
      checks++;
      if (mw[d] !== 72'd0 || mrow[d] !== 16'd0 || mcol[d] !== 16'd0) begin
        errors++;
        $display("FAIL reset_data dut%0d: got win=%h row=%0d col=%0d, required 0", d, mw[d], mrow[d], mcol[d]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (srdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got s_ready=%b, required 1", srdy[0]);
    end
  endtask

  task automatic test_ramp();
    int          fd0;
    logic [71:0] fw, lw;
    int          a [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int          b [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    for (int k = 0; k < 9; k++) begin
      fw[k*8 +: 8] = 8'(a[k]);
      lw[k*8 +: 8] = 8'(b[k]);
    end
    @(posedge clk); #1;
    win_cnt[0] = 0; fd0 = fd_cnt[0]; drv_done = 1'b0; mr[0] = 1'b1;
    fork
      run_frame(0, 0, 0, 1'b0, 16);
      watch(0, 1'b1);
    join
    checks++;
    if (win_cnt[0] != 4) begin errors++; $display("FAIL ramp_count: got %0d, required 4", win_cnt[0]); end
    checks++;
    if (first_w[0] !== {fw, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL ramp_first: got %h, required %h", first_w[0], {fw, 16'd1, 16'd1});
    end
    checks++;
    if (last_w[0] !== {lw, 16'd2, 16'd2}) begin
      errors++;
      $display("FAIL ramp_last: got %h, required %h", last_w[0], {lw, 16'd2, 16'd2});
    end
    checks++;
    if (fd_cnt[0] - fd0 != 1) begin errors++; $display("FAIL ramp_frame_done: got %0d pulses, required 1", fd_cnt[0] - fd0); end
    @(negedge clk);
    checks++;
    if (fdn[0] !== 1'b0) begin errors++; $display("FAIL frame_done_width: got %b a cycle later, required 0", fdn[0]); end
  endtask

  task automatic test_backpressure();
    int          fd0, n;
    logic [71:0] held;
    @(posedge clk); #1;
    win_cnt[0] = 0; fd0 = fd_cnt[0]; drv_done = 1'b0; mr[0] = 1'b0;
    fork
      run_frame(0, 0, 0, 1'b0, 16);
      watch(0, 1'b1);
      begin
        n = 0;
        @(negedge clk);
        while (!mv[0] && n < 2000) begin n++; @(negedge clk); end
        checks++;
        if (!mv[0]) begin
          errors++;
          $display("FAIL bp_no_window: got m_valid=%b, required 1", mv[0]);
        end else begin
          held = mw[0];
          for (int i = 0; i < 5; i++) begin
            checks++;
            if (srdy[0] !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d: got %b, required 0", i, srdy[0]); end
            checks++;
            if (mv[0] !== 1'b1 || mw[0] !== held) begin
              errors++;
              $display("FAIL bp_hold cycle %0d: got valid=%b win=%h, required 1 %h", i, mv[0], mw[0], held);
            end
            @(negedge clk);
          end
        end
        @(posedge clk); #1;
        mr[0] = 1'b1;
      end
    join
    checks++;
    if (win_cnt[0] != 4) begin errors++; $display("FAIL bp_count: got %0d, required 4", win_cnt[0]); end
    checks++;
    if (fd_cnt[0] - fd0 != 1) begin errors++; $display("FAIL bp_frame_done: got %0d pulses, required 1", fd_cnt[0] - fd0); end
  endtask

  task automatic test_gaps();
    @(posedge clk); #1;
    win_cnt[1] = 0; drv_done = 1'b0; mr[1] = 1'b1;
    fork
      run_frame(1, 0, 0, 1'b1, 64);
      watch(1, 1'b1);
    join
    checks++;
    if (win_cnt[1] != 36) begin errors++; $display("FAIL gaps_count: got %0d, required 36", win_cnt[1]); end
    checks++;
    if (last_w[1].win[39:32] !== 8'(8 * last_w[1].row + last_w[1].col) || last_w[1].row !== 16'd6) begin
      errors++;
      $display("FAIL gaps_centre: got centre=%0d row=%0d col=%0d, required 54 at (6,6)",
               last_w[1].win[39:32], last_w[1].row, last_w[1].col);
    end
  endtask

  task automatic test_back_to_back();
    int fd0;
    @(posedge clk); #1;
    fd0 = fd_cnt[0]; drv_done = 1'b0; mr[0] = 1'b1;
    fork
      begin
        run_frame(0, 0, 0, 1'b0, 16);
        run_frame(0, 0, 100, 1'b0, 16);
      end
      begin
        watch(0, 1'b1);
        win_cnt[0] = 0;
        watch(0, 1'b1);
      end
    join
    checks++;
    if (win_cnt[0] != 4) begin errors++; $display("FAIL b2b_count: got %0d, required 4", win_cnt[0]); end
    checks++;
    if (first_w[0].win[39:32] !== 8'd105 || first_w[0].row !== 16'd1 || first_w[0].col !== 16'd1) begin
      errors++;
      $display("FAIL b2b_first: got centre=%0d at (%0d,%0d), required 105 at (1,1)",
               first_w[0].win[39:32], first_w[0].row, first_w[0].col);
    end
    checks++;
    if (fd_cnt[0] - fd0 != 2) begin errors++; $display("FAIL b2b_frame_done: got %0d pulses, required 2", fd_cnt[0] - fd0); end
  endtask

  task automatic test_reset_midframe();
    int fd0;
    @(posedge clk); #1;
    drv_done = 1'b0; mr[0] = 1'b1;
    fork
      run_frame(0, 0, 50, 1'b0, 6);
      watch(0, 1'b0);
    join
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (srdy[0] !== 1'b0 || mv[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: got s_ready=%b m_valid=%b, required 0 0", srdy[0], mv[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q0.delete();
    win_cnt[0] = 0; fd0 = fd_cnt[0]; drv_done = 1'b0;
    fork
      run_frame(0, 0, 0, 1'b0, 16);
      watch(0, 1'b1);
    join
    checks++;
    if (win_cnt[0] != 4) begin errors++; $display("FAIL midreset_count: got %0d, required 4", win_cnt[0]); end
    checks++;
    if (fd_cnt[0] - fd0 != 1) begin errors++; $display("FAIL midreset_frame_done: got %0d pulses, required 1", fd_cnt[0] - fd0); end
  endtask

  task automatic test_impulse();
    @(posedge clk); #1;
    win_cnt[2] = 0; drv_done = 1'b0; mr[2] = 1'b1;
    fork
      run_frame(2, 1, 0, 1'b0, 25);
      watch(2, 1'b1);
    join
    checks++;
    if (win_cnt[2] != 9) begin errors++; $display("FAIL impulse_windows: got %0d, required 9", win_cnt[2]); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      sv[d] = 1'b0; sd[d] = 8'd0; mr[d] = 1'b1;
      win_cnt[d] = 0; fd_cnt[d] = 0;
      first_w[d] = '0; last_w[d] = '0;
    end
    drv_done = 1'b0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
    test_impulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
